// File: rtl/sipo_ctrl_pkg.sv
// Shared types and helpers for the SIPO word receive controller.
// Holds the FSM state encoding and the bit-counter width helper.
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Bits needed to index DATA_WIDTH serial positions (ceil(log2(w)), minimum 1).
    function automatic int unsigned bit_cnt_width(input int unsigned w);
        int unsigned n;
        n = 1;
        while ((32'd1 << n) < w) n++;
        return n;
    endfunction

endpackage

// File: rtl/sipo_shift_stage.sv
// Serial-in/parallel-out shift register; falling-edge clocked, first bit ends in MSB.
// Synchronous clear has priority over shifting.
module sipo_shift_stage #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Clear_In,
    input  logic                  Shift_En_In,
    input  logic                  Serial_Data_In,
    output logic [DATA_WIDTH-1:0] Shift_Data_Out
);

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            Shift_Data_Out <= '0;
        end else if (Clear_In) begin
            Shift_Data_Out <= '0;
        end else if (Shift_En_In) begin
            Shift_Data_Out <= {Shift_Data_Out[DATA_WIDTH-2:0], Serial_Data_In};
        end
    end

endmodule

// File: rtl/sipo_word_receive_controller.sv
// Frames serial bits into DATA_WIDTH-bit words and commits them into a one-entry
// valid/ready holding register, flagging overrun and counting committed words.
module sipo_word_receive_controller
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Start_In,
    input  logic                  Serial_Valid_In,
    input  logic                  Serial_Data_In,
    input  logic                  Word_Ready_In,
    output logic [DATA_WIDTH-1:0] Word_Data_Out,
    output logic                  Word_Valid_Out,
    output logic                  Busy_Out,
    output logic                  Overrun_Out,
    input  logic                  Clear_Overrun_In,
    output logic [CNT_WIDTH-1:0]  Word_Count_Out
);

    localparam int unsigned BW = bit_cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                  state;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    sh_clear;
    logic                    sh_en;
    logic                    commit_now;
    logic                    can_load;
    logic                    last_bit;

    // Start_In always restarts assembly, so it also discards a strobe on the same edge.
    always_comb begin
        sh_clear   = !Enable_In || Start_In;
        sh_en      = Enable_In && !Start_In && (state == ST_SHIFT) && Serial_Valid_In;
        commit_now = Enable_In && (state == ST_COMMIT);
        can_load   = !Word_Valid_Out || Word_Ready_In;
        last_bit   = (bit_cnt == LAST_BIT);
    end

    sipo_shift_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .Clk_In        (Clk_In),
        .Reset_In      (Reset_In),
        .Clear_In      (sh_clear),
        .Shift_En_In   (sh_en),
        .Serial_Data_In(Serial_Data_In),
        .Shift_Data_Out(shreg)
    );

    assign Busy_Out = (state != ST_IDLE);

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            Word_Data_Out  <= '0;
            Word_Valid_Out <= 1'b0;
            Overrun_Out    <= 1'b0;
            Word_Count_Out <= '0;
        end else begin
            // A commit on the same edge as an accept keeps Valid high with the new word.
            if (commit_now && can_load) begin
                Word_Data_Out  <= shreg;
                Word_Valid_Out <= 1'b1;
                Word_Count_Out <= Word_Count_Out + 1'b1;
            end else if (Word_Valid_Out && Word_Ready_In) begin
                Word_Valid_Out <= 1'b0;
            end

            if (commit_now && !can_load) begin
                Overrun_Out <= 1'b1;
            end else if (Clear_Overrun_In) begin
                Overrun_Out <= 1'b0;
            end

            if (!Enable_In) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Start_In) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (Start_In) begin
                            bit_cnt <= '0;
                        end else if (Serial_Valid_In) begin
                            if (last_bit) begin
                                state   <= ST_COMMIT;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        state   <= Start_In ? ST_SHIFT : ST_IDLE;
                        bit_cnt <= '0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_word_receive_controller.sv
// Bench for sipo_word_receive_controller: directed frames plus random traffic,
// compared every falling edge against a queue-based frame/holding model.
module tb_sipo_word_receive_controller;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          start;
    logic          sv;
    logic          sd;
    logic          rdy;
    logic          clr;
    logic [W-1:0]  data;
    logic          valid;
    logic          busy;
    logic          over;
    logic [CW-1:0] count;

    int total;
    int bad;

    // Reference model state
    bit        q[$];
    bit        m_frame;
    bit        m_done;
    logic [W-1:0] m_word;
    logic [W-1:0] m_data;
    bit        m_valid;
    bit        m_over;
    int        m_count;

    sipo_word_receive_controller #(
        .DATA_WIDTH(W),
        .CNT_WIDTH (CW)
    ) dut (
        .Clk_In          (clk),
        .Reset_In        (rst),
        .Enable_In       (en),
        .Start_In        (start),
        .Serial_Valid_In (sv),
        .Serial_Data_In  (sd),
        .Word_Ready_In   (rdy),
        .Word_Data_Out   (data),
        .Word_Valid_Out  (valid),
        .Busy_Out        (busy),
        .Overrun_Out     (over),
        .Clear_Overrun_In(clr),
        .Word_Count_Out  (count)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".data"},  32'(data),  32'(m_data));
        check_eq({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check_eq({tag, ".busy"},  32'(busy),  32'(m_frame || m_done));
        check_eq({tag, ".over"},  32'(over),  32'(m_over));
        check_eq({tag, ".count"}, 32'(count), 32'(m_count % 256));
    endtask

    task automatic model_reset();
        q.delete();
        m_frame = 0; m_done = 0; m_word = '0; m_data = '0;
        m_valid = 0; m_over = 0; m_count = 0;
    endtask

    // One falling edge of model behaviour, given the inputs present at that edge.
    task automatic model_edge();
        bit nv, no;
        nv = m_valid && !(m_valid && rdy);
        no = m_over && !clr;
        if (en && m_done) begin
            if (!m_valid || rdy) begin
                m_data = m_word; nv = 1; m_count++;
            end else begin
                no = 1;
            end
        end
        m_valid = nv;
        m_over  = no;
        if (!en) begin
            m_frame = 0; m_done = 0; q.delete();
        end else if (m_done) begin
            m_done = 0; m_frame = start; q.delete();
        end else if (start) begin
            m_frame = 1; q.delete();
        end else if (m_frame && sv) begin
            q.push_back(sd);
            if (q.size() == W) begin
                m_word = '0;
                foreach (q[i]) m_word = (m_word << 1) | W'(q[i]);
                m_frame = 0; m_done = 1;
            end
        end
    endtask

    task automatic step(input bit i_en, input bit i_st, input bit i_sv, input bit i_sd,
                        input bit i_rdy, input bit i_clr, input string tag);
        en = i_en; start = i_st; sv = i_sv; sd = i_sd; rdy = i_rdy; clr = i_clr;
        @(negedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        #3 rst = 1'b0;
    endtask

    // Start pulse plus W strobes, MSB first, Ready held low.
    task automatic frame_bits(input logic [W-1:0] v, input string tag);
        logic [W-1:0] t;
        t = v;
        step(1, 1, 0, 0, 0, 0, tag);
        for (int i = W - 1; i >= 0; i--) step(1, 0, 1, t[i], 0, 0, tag);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 0; en = 1; start = 0; sv = 0; sd = 0; rdy = 0; clr = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic frame 1011 and commit latency
        frame_bits(4'b1011, "f1");
        check_eq("f1.valid_before_commit", 32'(valid), 32'd0);
        step(1, 0, 0, 0, 0, 0, "f1c");
        check_eq("f1.data", 32'(data), 32'hB);
        check_eq("f1.valid", 32'(valid), 32'd1);
        check_eq("f1.count", 32'(count), 32'd1);

        // Second word while pending -> overrun, holding data kept
        frame_bits(4'b0110, "f2");
        step(1, 0, 0, 0, 0, 0, "f2c");
        check_eq("f2.over", 32'(over), 32'd1);
        check_eq("f2.data", 32'(data), 32'hB);
        check_eq("f2.count", 32'(count), 32'd1);

        // Clear overrun, then ready on the commit edge replaces the pending word
        step(1, 0, 0, 0, 0, 1, "clr");
        check_eq("clr.over", 32'(over), 32'd0);
        frame_bits(4'b0110, "f3");
        step(1, 0, 0, 0, 1, 0, "f3c");
        check_eq("f3.data", 32'(data), 32'h6);
        check_eq("f3.valid", 32'(valid), 32'd1);
        check_eq("f3.over", 32'(over), 32'd0);

        // Consume, then restart after two bits discards the partial word
        step(1, 0, 0, 0, 1, 0, "take");
        check_eq("take.valid", 32'(valid), 32'd0);
        step(1, 1, 0, 0, 0, 0, "f4");
        step(1, 0, 1, 1, 0, 0, "f4");
        step(1, 0, 1, 1, 0, 0, "f4");
        frame_bits(4'b0010, "f4");
        step(1, 0, 0, 0, 0, 0, "f4c");
        check_eq("f4.data", 32'(data), 32'h2);

        // Reset mid-frame after 3 bits
        step(1, 0, 0, 0, 1, 0, "take2");
        step(1, 1, 0, 0, 0, 0, "f5");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0, "f5");
        do_reset();
        check_eq("rst.busy", 32'(busy), 32'd0);
        frame_bits(4'b1001, "f5b");
        step(1, 0, 0, 0, 0, 0, "f5c");
        check_eq("f5.data", 32'(data), 32'h9);

        // Enable low mid-frame after 3 bits
        step(1, 0, 0, 0, 1, 0, "take3");
        step(1, 1, 0, 0, 0, 0, "f6");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, "f6");
        step(0, 0, 1, 1, 0, 0, "dis");
        check_eq("dis.busy", 32'(busy), 32'd0);
        frame_bits(4'b1110, "f6b");
        step(1, 0, 0, 0, 0, 0, "f6c");
        check_eq("f6.data", 32'(data), 32'hE);

        // Overrun set and clear on the same edge: set wins
        frame_bits(4'b0101, "f7");
        step(1, 0, 0, 0, 0, 1, "f7c");
        check_eq("f7.over_setwins", 32'(over), 32'd1);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            step(($urandom % 25) != 0, ($urandom % 12) == 0, ($urandom % 3) != 0,
                 1'($urandom), 1'($urandom), ($urandom % 10) == 0, "rnd");
        end

        // Counter wrap over 256 committed words
        do_reset();
        for (int i = 0; i < 256; i++) begin
            frame_bits(W'(i), "wrap");
            step(1, 0, 0, 0, 1, 0, "wrapc");
            if (i == 254) check_eq("wrap.255", 32'(count), 32'd255);
        end
        check_eq("wrap.zero", 32'(count), 32'd0);
        check_eq("wrap.data", 32'(data), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
